sfp_seq: RTL and testbench

Sequencer for the SFP accumulate/ReLU stage. It sits between the MAC array's last-row psum outputs and the SFP/output FIFO. It admits exactly `num_k` partial sums per column into the SFP accumulators, then writes each finished output vector to the output FIFO and clears the accumulators. It repeats this for `num_tiles` vectors and signals completion.

---
 rtl/sfp_pkg.sv | 25 ++
 rtl/sfp_col_cnt.sv | 50 +++++
 rtl/sfp_seq.sv | 134 +++++++++++++
 tb/tb_sfp_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sfp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sfp_pkg
// Description : Shared types and default widths for the SFP sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sfp_pkg;

    // Default number of SFP lanes / MAC columns
    localparam int unsigned SFP_COL  = 8;
    // Default width of num_k and the per-column counters
    localparam int unsigned SFP_K_BW = 8;
    // Default width of num_tiles and tile_idx
    localparam int unsigned SFP_T_BW = 16;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sfp_state_t;

endpackage : sfp_pkg
`default_nettype wire

// File: rtl/sfp_col_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sfp_col_cnt
// Description : Per-column psum admission counter. Counts handshakes up to
//               'limit'; ready while below it. hit_next flags that the
//               counter will sit at 'limit' after this edge, which lets the
//               sequencer leave ACCUM right after the last accept.
// Revision    : 1.0 - initial release
// ============================================================================
module sfp_col_cnt
    import sfp_pkg::*;
#(
    parameter int unsigned K_BW = SFP_K_BW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    input  logic            clr,
    input  logic [K_BW-1:0] limit,
    output logic            ready,
    output logic            hit_next
);

    logic [K_BW-1:0] cnt_q;
    logic [K_BW-1:0] cnt_d;

    // Next count: clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + K_BW'(1);
        end
    end

    // Counter register, cleared asynchronously on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ready    = (cnt_q < limit);
    assign hit_next = (cnt_d == limit);

endmodule : sfp_col_cnt
`default_nettype wire

// File: rtl/sfp_seq.sv
`default_nettype none
// ============================================================================
// Module      : sfp_seq
// Description : Sequencer for the SFP accumulate/ReLU stage. Admits eff_k
//               psums per column, then writes the finished vector to the
//               output FIFO while clearing the accumulators, num_tiles times.
// Revision    : 1.0 - initial release
// ============================================================================
module sfp_seq
    import sfp_pkg::*;
#(
    parameter int unsigned COL  = SFP_COL,
    parameter int unsigned K_BW = SFP_K_BW,
    parameter int unsigned T_BW = SFP_T_BW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [K_BW-1:0] num_k,
    input  logic [T_BW-1:0] num_tiles,
    input  logic [COL-1:0]  psum_valid,
    output logic [COL-1:0]  psum_ready,
    output logic [COL-1:0]  sfp_valid_in,
    output logic [COL-1:0]  sfp_clr,
    input  logic            ofifo_full,
    output logic [COL-1:0]  ofifo_wr,
    output logic            busy,
    output logic            done,
    output logic [T_BW-1:0] tile_idx
);

    sfp_state_t      state_q;
    sfp_state_t      state_d;
    logic [K_BW-1:0] eff_k_q;
    logic [K_BW-1:0] eff_k_d;
    logic [T_BW-1:0] num_tiles_q;
    logic [T_BW-1:0] num_tiles_d;
    logic [T_BW-1:0] tile_idx_q;
    logic [T_BW-1:0] tile_idx_d;

    logic [COL-1:0]  w_col_ready;
    logic [COL-1:0]  w_col_hit;
    logic [COL-1:0]  w_accept;
    logic            w_wr;
    logic            w_start_acc;
    logic            w_cnt_clr;

    // Counters only admit psums while accumulating; elsewhere ready is low
    assign psum_ready   = (state_q == ST_ACCUM) ? w_col_ready : '0;
    assign w_accept     = psum_valid & psum_ready;
    assign sfp_valid_in = w_accept;
    // A fresh job starts from zero, and every vector write restarts counting
    assign w_cnt_clr    = w_wr | w_start_acc;

    generate
        for (genvar c = 0; c < COL; c++) begin : g_col
            sfp_col_cnt #(
                .K_BW (K_BW)
            ) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .inc      (w_accept[c]),
                .clr      (w_cnt_clr),
                .limit    (eff_k_q),
                .ready    (w_col_ready[c]),
                .hit_next (w_col_hit[c])
            );
        end
    endgenerate

    // Next-state, config latch and tile counter logic
    always_comb begin
        state_d     = state_q;
        eff_k_d     = eff_k_q;
        num_tiles_d = num_tiles_q;
        tile_idx_d  = tile_idx_q;
        w_wr        = 1'b0;
        w_start_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    eff_k_d     = (num_k == '0) ? K_BW'(1) : num_k;
                    num_tiles_d = num_tiles;
                    tile_idx_d  = '0;
                    state_d     = (num_tiles == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // Leave as soon as every column's counter lands on eff_k
                if (&w_col_hit) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // FIFO write and accumulator clear share the same edge
                if (!ofifo_full) begin
                    w_wr       = 1'b1;
                    tile_idx_d = tile_idx_q + T_BW'(1);
                    state_d    = ((tile_idx_q + T_BW'(1)) == num_tiles_q) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and configuration registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            eff_k_q     <= '0;
            num_tiles_q <= '0;
            tile_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            eff_k_q     <= eff_k_d;
            num_tiles_q <= num_tiles_d;
            tile_idx_q  <= tile_idx_d;
        end
    end

    assign ofifo_wr = {COL{w_wr}};
    assign sfp_clr  = {COL{w_wr}};
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign tile_idx = tile_idx_q;

endmodule : sfp_seq
`default_nettype wire

// File: tb/tb_sfp_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfp_seq
// Description : Self-checking bench for sfp_seq. Stimulus pushes expected
//               FIFO-write and done events into a queue; a monitor pops and
//               compares them whenever the DUT presents a write or done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfp_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  num_k;
    logic [15:0] num_tiles;
    logic [7:0]  psum_valid;
    logic [7:0]  psum_ready;
    logic [7:0]  sfp_valid_in;
    logic [7:0]  sfp_clr;
    logic        ofifo_full;
    logic [7:0]  ofifo_wr;
    logic        busy;
    logic        done;
    logic [15:0] tile_idx;

    typedef struct packed {
        logic        is_done;
        logic [15:0] tidx;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  vc[8];
    int  nwr = 0;

    sfp_seq u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_k        (num_k),
        .num_tiles    (num_tiles),
        .psum_valid   (psum_valid),
        .psum_ready   (psum_ready),
        .sfp_valid_in (sfp_valid_in),
        .sfp_clr      (sfp_clr),
        .ofifo_full   (ofifo_full),
        .ofifo_wr     (ofifo_wr),
        .busy         (busy),
        .done         (done),
        .tile_idx     (tile_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on every FIFO write or done pulse
    initial begin
        ev_t ev;
        for (int c = 0; c < 8; c++) vc[c] = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int c = 0; c < 8; c++) if (sfp_valid_in[c]) vc[c]++;
                if (ofifo_full && busy) begin
                    check("no_wr_while_full", {24'd0, ofifo_wr}, 32'd0);
                    check("no_clr_while_full", {24'd0, sfp_clr}, 32'd0);
                end
                if ((|ofifo_wr) || done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", {15'd0, done, tile_idx}, 32'hFFFF_FFFF);
                    end else begin
                        ev = exp_q.pop_front();
                        check("event_kind", {31'd0, done}, {31'd0, ev.is_done});
                        check("event_tile_idx", {16'd0, tile_idx}, {16'd0, ev.tidx});
                        if (!ev.is_done) begin
                            nwr++;
                            check("ofifo_wr_mask", {24'd0, ofifo_wr}, 32'hFF);
                            check("sfp_clr_mask", {24'd0, sfp_clr}, 32'hFF);
                        end
                    end
                end
            end
        end
    end

    // Runs one job; mode 0 all valid, 1 skewed col7, 2 FIFO full k=3..7,
    // 3 spurious start while busy
    task automatic run_job(input string nm, input logic [7:0] nk, input logic [15:0] nt,
                           input int mode, input int exp_kd, input int exp_v, input int exp_wr);
        int kd;
        int k;
        int v0[8];
        int wr0;
        for (int t = 0; t < int'(nt); t++) exp_q.push_back('{is_done: 1'b0, tidx: 16'(t)});
        exp_q.push_back('{is_done: 1'b1, tidx: nt});
        for (int c = 0; c < 8; c++) v0[c] = vc[c];
        wr0 = nwr;
        @(posedge clk); #1;
        start = 1'b1; num_k = nk; num_tiles = nt; psum_valid = '0;
        @(posedge clk); #1;
        start = 1'b0;
        kd = -1;
        k  = 1;
        while (k <= 60) begin
            case (mode)
                1:       psum_valid = {(k % 3 == 0), 7'h7F};
                default: psum_valid = 8'hFF;
            endcase
            ofifo_full = (mode == 2) && (k >= 3) && (k <= 7);
            if (mode == 3) begin
                start = (k == 1); num_k = 8'd7; num_tiles = 16'd3;
            end
            #1;
            if (k == 1) begin
                check({nm, "_busy_k1"}, {31'd0, busy}, 32'd1);
                check({nm, "_ready_k1"}, {24'd0, psum_ready}, (nt != 0) ? 32'hFF : 32'h0);
            end
            if (mode == 1 && k == 5) begin
                check({nm, "_col0_ready_drop"}, {31'd0, psum_ready[0]}, 32'd0);
                check({nm, "_col7_ready_held"}, {31'd0, psum_ready[7]}, 32'd1);
            end
            if (mode == 1 && k == 12) check({nm, "_no_drain_early"}, {24'd0, ofifo_wr}, 32'd0);
            if (done) begin
                kd = k;
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0; psum_valid = '0; ofifo_full = 1'b0;
        check({nm, "_done_cycle"}, kd, exp_kd);
        @(posedge clk); #1;
        check({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
        check({nm, "_tile_idx"}, {16'd0, tile_idx}, {16'd0, nt});
        check({nm, "_writes"}, nwr - wr0, exp_wr);
        check({nm, "_accepts_c0"}, vc[0] - v0[0], exp_v);
        check({nm, "_accepts_c3"}, vc[3] - v0[3], exp_v);
        check({nm, "_accepts_c7"}, vc[7] - v0[7], exp_v);
        check({nm, "_sb_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; num_k = '0; num_tiles = '0;
        psum_valid = '0; ofifo_full = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {24'd0, psum_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_tile_idx", {16'd0, tile_idx}, 32'd0);
        check("rst_wr", {24'd0, ofifo_wr}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // k=3, one tile: accepts 1..3, write 4, done 5
        run_job("basic", 8'd3, 16'd1, 0, 5, 3, 1);
        // skewed: col7 accepts at 3,6,9,12; write 13, done 14
        run_job("skew", 8'd4, 16'd1, 1, 14, 4, 1);
        // FIFO full k=3..7 in DRAIN; write at 8, done 9
        run_job("full", 8'd2, 16'd1, 2, 9, 2, 1);
        // num_k=0 treated as 1: 2 tiles x 2 cycles + 1
        run_job("k0", 8'd0, 16'd2, 0, 5, 2, 2);
        // zero tiles: done the cycle after start
        run_job("t0", 8'd5, 16'd0, 0, 1, 0, 0);
        // start while busy is ignored: still k=2, 1 tile
        run_job("ign", 8'd2, 16'd1, 3, 4, 2, 1);

        // reset in the middle of ACCUM with cnt = 2
        @(posedge clk); #1;
        start = 1'b1; num_k = 8'd4; num_tiles = 16'd1; psum_valid = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midrst_ready", {24'd0, psum_ready}, 32'd0);
        check("midrst_valid_in", {24'd0, sfp_valid_in}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_wr", {24'd0, ofifo_wr}, 32'd0);
        check("midrst_clr", {24'd0, sfp_clr}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_tile_idx", {16'd0, tile_idx}, 32'd0);
        psum_valid = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        run_job("post_rst", 8'd3, 16'd1, 0, 5, 3, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sfp_seq
`default_nettype wire
